// File: rtl/decode_stage.sv
// decode_stage: MIPS-subset instruction decode with a 32x32 register file,
// write-through bypass from the write-back port, and a registered ID/EX
// boundary with flush/stall control.
module decode_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic [31:0] data_A,
    output logic [31:0] data_B,
    output logic [31:0] SignExtImm,
    output logic [4:0]  shamt,
    output logic [1:0]  mux_2_flag,
    output logic [3:0]  Alu_function,
    output logic [4:0]  dest_reg,
    output logic        reg_write,
    output logic        ex_valid,
    output logic        illegal
);

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
        ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLL = 4'd7,
        ALU_SRL = 4'd8, ALU_SRA = 4'd9
    } alu_op_e;

    // Operand-B select encoding seen by Execute.
    localparam logic [1:0] SEL_REG = 2'd0;
    localparam logic [1:0] SEL_IMM = 2'd1;
    localparam logic [1:0] SEL_SHAMT = 2'd2;

    typedef struct packed {
        logic [31:0] data_a;
        logic [31:0] data_b;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic [1:0]  mux_sel;
        alu_op_e     alu;
        logic [4:0]  dest;
        logic        reg_write;
        logic        valid;
        logic        illegal;
    } id_ex_t;

    // Instruction fields
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm16;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign funct  = instr[5:0];
    assign imm16  = instr[15:0];

    logic [31:0] rf [32];
    logic [31:0] rs_val;
    logic [31:0] rt_val;

    // Register file write port; entry 0 is never written so it stays zero.
    // NOTE: the register file must clear on reset, so this memory is reset
    // explicitly; memories without that need are better left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (wb_en && (wb_addr != 5'd0)) begin
            // NOTE: sequential state is updated with non-blocking assignments
            // so every flop samples pre-edge values regardless of block order.
            rf[wb_addr] <= wb_data;
        end
    end

    // Read ports with write-through bypass from the write-back port.
    always_comb begin
        if (rs == 5'd0)                      rs_val = '0;
        else if (wb_en && (wb_addr == rs))   rs_val = wb_data;
        else                                 rs_val = rf[rs];
        if (rt == 5'd0)                      rt_val = '0;
        else if (wb_en && (wb_addr == rt))   rt_val = wb_data;
        else                                 rt_val = rf[rt];
    end

    logic    dec_legal;
    logic    dec_zext;
    alu_op_e dec_alu;
    logic [1:0]  dec_sel;
    logic [4:0]  dec_dest;
    logic [31:0] dec_a;
    id_ex_t      dec;

    // Decode opcode/funct into ALU op, operand select and destination.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value
        // unassigned, which would otherwise infer a latch.
        dec_legal = 1'b0;
        dec_zext  = 1'b0;
        dec_alu   = ALU_ADD;
        dec_sel   = SEL_REG;
        dec_dest  = rt;
        dec_a     = rs_val;
        unique case (opcode)
            6'h00: begin
                dec_dest  = rd;
                dec_legal = 1'b1;
                case (funct)
                    6'h20, 6'h21: dec_alu = ALU_ADD;
                    6'h22, 6'h23: dec_alu = ALU_SUB;
                    6'h24:        dec_alu = ALU_AND;
                    6'h25:        dec_alu = ALU_OR;
                    6'h26:        dec_alu = ALU_XOR;
                    6'h27:        dec_alu = ALU_NOR;
                    6'h2A:        dec_alu = ALU_SLT;
                    6'h00: begin dec_alu = ALU_SLL; dec_sel = SEL_SHAMT; dec_a = rt_val; end
                    6'h02: begin dec_alu = ALU_SRL; dec_sel = SEL_SHAMT; dec_a = rt_val; end
                    6'h03: begin dec_alu = ALU_SRA; dec_sel = SEL_SHAMT; dec_a = rt_val; end
                    default:      dec_legal = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin dec_legal = 1'b1; dec_alu = ALU_ADD; dec_sel = SEL_IMM; end
            6'h0A:        begin dec_legal = 1'b1; dec_alu = ALU_SLT; dec_sel = SEL_IMM; end
            6'h0C: begin dec_legal = 1'b1; dec_alu = ALU_AND; dec_sel = SEL_IMM; dec_zext = 1'b1; end
            6'h0D: begin dec_legal = 1'b1; dec_alu = ALU_OR;  dec_sel = SEL_IMM; dec_zext = 1'b1; end
            6'h0E: begin dec_legal = 1'b1; dec_alu = ALU_XOR; dec_sel = SEL_IMM; dec_zext = 1'b1; end
            default: ;
        endcase
    end

    // Assemble the bundle that a normal load writes into ID/EX.
    always_comb begin
        dec.data_a    = dec_a;
        dec.data_b    = rt_val;
        dec.imm       = dec_zext ? {16'h0000, imm16} : {{16{imm16[15]}}, imm16};
        dec.shamt     = instr[10:6];
        dec.mux_sel   = dec_sel;
        dec.alu       = dec_alu;
        dec.dest      = dec_dest;
        dec.reg_write = dec_dest != 5'd0;
        dec.valid     = 1'b1;
        dec.illegal   = 1'b0;
    end

    id_ex_t id_ex;

    // ID/EX register: flush beats stall, stall holds, otherwise load or bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex <= '0;
        end else if (flush) begin
            id_ex <= '0;
        end else if (stall) begin
            id_ex.illegal <= 1'b0;
        end else if (!instr_valid) begin
            id_ex <= '0;
        end else if (!dec_legal) begin
            id_ex         <= '0;
            id_ex.illegal <= 1'b1;
        end else begin
            id_ex <= dec;
        end
    end

    assign data_A       = id_ex.data_a;
    assign data_B       = id_ex.data_b;
    assign SignExtImm   = id_ex.imm;
    assign shamt        = id_ex.shamt;
    assign mux_2_flag   = id_ex.mux_sel;
    assign Alu_function = id_ex.alu;
    assign dest_reg     = id_ex.dest;
    assign reg_write    = id_ex.reg_write;
    assign ex_valid     = id_ex.valid;
    assign illegal      = id_ex.illegal;

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode stage and ID/EX pipeline register that produces the operand and control bundle consumed by the Execute stage. The block holds the 32×32 general register file, decodes one 32-bit MIPS-subset instruction per cycle, and builds the sign- or zero-extended immediate, the shift amount, the operand-B select and the 4-bit ALU function code. Results are registered into the ID/EX boundary, with stall and flush control. The block also accepts the write-back port from the end of the pipeline.

## Interface
- `RESET_PC_UNUSED` — none. The block has no parameters; widths are fixed by the ISA.
- `clk` input 1 — rising-edge clock.
- `rst_n` input 1 — asynchronous, active-low reset.
- `instr` input 32 — fetched instruction.
- `instr_valid` input 1 — `instr` is meaningful this cycle.
- `stall` input 1 — hold the ID/EX register contents.
- `flush` input 1 — load a bubble into ID/EX.
- `wb_en` input 1 — register-file write enable.
- `wb_addr` input 5 — write address.
- `wb_data` input 32 — write data.
- `data_A` output 32 — registered rs value; rt value for shifts.
- `data_B` output 32 — registered rt value.
- `SignExtImm` output 32 — registered extended immediate.
- `shamt` output 5 — registered `instr[10:6]`.
- `mux_2_flag` output 2 — operand-B select: 0 = `data_B`, 1 = `SignExtImm`, 2 = `shamt`.
- `Alu_function` output 4 — ALU operation code.
- `dest_reg` output 5 — write-back destination: rd for R-type, rt for I-type.
- `reg_write` output 1 — the EX instruction writes `dest_reg`.
- `ex_valid` output 1 — the ID/EX register holds a real instruction.
- `illegal` output 1 — one-cycle pulse when a valid instruction is unsupported.

## Operation
- ALU codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, NOR 5, SLT 6, SLL 7, SRL 8, SRA 9.
- R-type instructions (opcode 0x00) decode on funct:
  - 0x20/0x21 → ADD; 0x22/0x23 → SUB.
  - 0x24 → AND; 0x25 → OR; 0x26 → XOR; 0x27 → NOR; 0x2A → SLT.
  - For these: `mux_2_flag` = 0.
  - 0x00 → SLL; 0x02 → SRL; 0x03 → SRA.
  - For shifts: `mux_2_flag` = 2 and `data_A` = rf[rt].
- I-type instructions:
  - Opcodes 0x08/0x09 → ADD and 0x0A → SLT, with the immediate sign-extended.
  - Opcodes 0x0C → AND, 0x0D → OR and 0x0E → XOR, with the immediate zero-extended.
  - For all I-type: `mux_2_flag` = 1.
- `SignExtImm` is always registered from the extension rule of the decoded opcode. It is don't-care for R-type and is registered as the sign-extended value.
- `reg_write` = 1 for every legal instruction whose `dest_reg` ≠ 0; otherwise 0.
- Any other opcode or funct with `instr_valid` = 1 is illegal:
  - load a bubble;
  - assert `illegal` for that cycle.
- Register file:
  - rf[0] always reads 0, and writes to address 0 are discarded.
  - The write occurs on the rising edge when `wb_en` = 1.
- Write-through bypass: if `wb_en` = 1, `wb_addr` ≠ 0 and `wb_addr` equals a read address, the read returns `wb_data` in the same cycle.
- Bubble: `ex_valid` = 0, `reg_write` = 0, `Alu_function` = 0, `mux_2_flag` = 0, `dest_reg` = 0. Data outputs are don't-care.

## Timing
- Decode latency is 1 cycle: `instr` sampled at edge N appears on the outputs after edge N.
- ID/EX update priority at each edge, highest first:
  1. `flush` → bubble, even when `stall` is also asserted.
  2. `stall` → hold all outputs.
  3. `instr_valid` = 0 → bubble.
  4. Otherwise, load the decode results.
- `illegal` is registered. It pulses only when a load actually occurs, so it is suppressed by `stall` and by `flush`.
- Register-file writes are independent of `stall` and `flush`.
- Reset (`rst_n` low, asynchronous, including mid-operation):
  - all outputs go to 0;
  - all 32 register entries clear to 0;
  - the first update occurs on the first rising edge after `rst_n` rises.

## Test plan
- Reset, then write rf[1] = 5 and rf[2] = 3. Issue `add $3,$1,$2` (0x00221820). Next cycle: `data_A` = 5, `data_B` = 3, `Alu_function` = 0, `mux_2_flag` = 0, `dest_reg` = 3, `reg_write` = 1, `ex_valid` = 1.
- Sign and zero extension:
  - `addi $4,$1,-1` (0x2024FFFF) → `SignExtImm` = 0xFFFFFFFF, `mux_2_flag` = 1, `dest_reg` = 4.
  - `ori $4,$1,0xFFFF` (0x3424FFFF) → `SignExtImm` = 0x0000FFFF, `Alu_function` = 3.
- `sll $5,$2,4` (0x00022900) → `data_A` = 3, `shamt` = 4, `mux_2_flag` = 2, `Alu_function` = 7.
- Bypass and register 0:
  - Drive `wb_en` = 1, `wb_addr` = 1, `wb_data` = 0xA5A5A5A5 in the same cycle as `add $3,$1,$2` → `data_A` = 0xA5A5A5A5.
  - A write to address 0 → rs = 0 still reads 0.
- Stall and flush:
  - With a valid add loaded, assert `stall` for 2 cycles while `instr` changes → outputs hold.
  - Assert `stall` and `flush` together → `ex_valid` = 0, `reg_write` = 0.
- Illegal instruction: opcode 0x3F → `illegal` pulses for exactly 1 cycle, with `ex_valid` = 0. Assert `rst_n` low mid-stream → all outputs are 0 immediately, without waiting for a clock edge.
